// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// bit-period computation and the width helper used to size counters.
package fifo_uart_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_POP    = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    function automatic int calc_cpb(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int log2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..cpb-1 while enabled and flags the last cycle
// of each line bit. Also intended for reuse by the receive side.
module uart_baud_cnt #(
    parameter int cpb   = 2,
    parameter int cnt_w = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(cpb - 1);

    logic [cnt_w-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == cnt_last) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // Independent of clr: the owner derives clr from bit_end.
    assign bit_end = en && (cnt_q == cnt_last);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one word per frame (honouring the one-cycle
// read latency) and serialises it as start, data LSB first, optional even parity, stop.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int clk_freq   = 100_000_000,
    parameter int baud_rate  = 115200,
    parameter int data_width = 8,
    parameter int parity_en  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  txd,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int cpb   = calc_cpb(clk_freq, baud_rate);
    localparam int cnt_w = log2(cpb);
    localparam int idx_w = log2(data_width) + 1;
    localparam logic [idx_w-1:0] last_idx = idx_w'(data_width - 1);

    generate
        if (cpb < 2) begin : g_bad_cpb
            $error("fifo_uart_tx: clk_freq/baud_rate must be at least 2");
        end
    endgenerate

    logic [2:0]            state_q, state_d;
    logic [data_width-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic [idx_w-1:0]      bit_idx_q, bit_idx_d;
    logic                  bit_end;
    logic                  cnt_en;

    assign cnt_en = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);

    uart_baud_cnt #(.cpb(cpb), .cnt_w(cnt_w)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_d != state_q),
        .en      (cnt_en),
        .bit_end (bit_end)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves a value unassigned and infers a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            ST_IDLE:   if (tx_en && !fifo_empty) state_d = ST_POP;
            ST_POP:    state_d = ST_LOAD;
            ST_LOAD: begin
                shift_d   = fifo_dout;
                parity_d  = ^fifo_dout;
                bit_idx_d = '0;
                state_d   = ST_START;
            end
            ST_START:  if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == last_idx)
                        state_d = (parity_en != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP: begin
                if (bit_end) state_d = (tx_en && !fifo_empty) ? ST_POP : ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // Outputs decode registered state only; reset forces IDLE and so txd high at once.
    always_comb begin
        txd = 1'b1;
        case (state_q)
            ST_START:  txd = 1'b0;
            ST_DATA:   txd = shift_q[0];
            ST_PARITY: txd = parity_q;
            default:   txd = 1'b1;
        endcase
    end

    assign fifo_rd_en = (state_q == ST_POP);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx at cpb=10: stimulus pushes hand-built line
// images, a monitor reconstructs each frame from txd and compares.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic       fifo_empty0 = 1'b1, fifo_empty1 = 1'b1;
    logic [7:0] fifo_dout0 = 8'h00, fifo_dout1 = 8'h00;
    logic       rd_en0, txd0, busy0, done0;
    logic       rd_en1, txd1, busy1, done1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [9:0] exp_q[$];

    int n_checks = 0;
    int n_pass = 0;
    int rd_cnt0 = 0;
    int pop_empty0 = 0;
    int pop_empty1 = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.clk_freq(1000), .baud_rate(100), .data_width(8), .parity_en(0)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty0), .fifo_dout(fifo_dout0),
        .fifo_rd_en(rd_en0), .txd(txd0), .busy(busy0), .frame_done(done0)
    );

    fifo_uart_tx #(.clk_freq(1000), .baud_rate(100), .data_width(8), .parity_en(1)) dut_p (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty1), .fifo_dout(fifo_dout1),
        .fifo_rd_en(rd_en1), .txd(txd1), .busy(busy1), .frame_done(done1)
    );

    // FIFO models: registered read data and empty flag; dout scrambles when not popped.
    always @(posedge clk) begin
        if (rd_en0) begin
            rd_cnt0++;
            if (q0.size() > 0) fifo_dout0 <= q0.pop_front();
            else pop_empty0++;
        end else begin
            fifo_dout0 <= fifo_dout0 ^ 8'hC3;
        end
        fifo_empty0 <= (q0.size() == 0);
    end

    always @(posedge clk) begin
        if (rd_en1) begin
            if (q1.size() > 0) fifo_dout1 <= q1.pop_front();
            else pop_empty1++;
        end else begin
            fifo_dout1 <= fifo_dout1 ^ 8'h5A;
        end
        fifo_empty1 <= (q1.size() == 0);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // sel: 0 rd_en0, 1 txd0 low, 2 done0, 3 txd1 low, 4 done1
    task automatic wait_sig(input int sel, input int budget, input string name, output int cycles);
        bit hit;
        hit = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            cycles++;
            case (sel)
                0: hit = (rd_en0 === 1'b1);
                1: hit = (txd0 === 1'b0);
                2: hit = (done0 === 1'b1);
                3: hit = (txd1 === 1'b0);
                4: hit = (done1 === 1'b1);
                default: hit = 1'b1;
            endcase
        end
        check(name, hit, 1);
    endtask

    // Monitor: one frame = 100 cycles from the start-bit edge; bit centres at c%10==5.
    initial begin : monitor
        logic [9:0] line;
        logic [9:0] expected;
        logic       cur;
        bit         stable, aborted;
        int         done_at;
        forever begin
            @(negedge clk);
            if (rst && txd0 === 1'b0) begin
                line = '0; cur = 1'b0; stable = 1'b1; aborted = 1'b0; done_at = -1;
                for (int c = 0; c < 100; c++) begin
                    if (c > 0) @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c % 10 == 0) cur = txd0;
                    else if (txd0 !== cur) stable = 1'b0;
                    if (c % 10 == 5) line[c/10] = txd0;
                    if (done0 === 1'b1 && done_at < 0) done_at = c;
                end
                if (aborted) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    expected = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
                    check("frame_line", line, expected);
                    check("bit_stable", stable, 1);
                    check("frame_done_pos", done_at, 99);
                end
            end
        end
    end

    initial begin : stimulus
        int n, base;
        int pdone;
        logic [10:0] pline;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", txd0, 1);
        check("rst_busy", busy0, 0);
        check("rst_rd_en", rd_en0, 0);
        check("rst_frame_done", done0, 0);
        rst = 1'b1;

        // Empty FIFO with tx_en high: no pop, line idle, not busy.
        tx_en = 1'b1;
        begin
            bit seen_low, seen_busy;
            seen_low = 1'b0; seen_busy = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (txd0 !== 1'b1) seen_low = 1'b1;
                if (busy0 !== 1'b0) seen_busy = 1'b1;
            end
            check("empty_rd_count", rd_cnt0, 0);
            check("empty_txd_low_seen", seen_low, 0);
            check("empty_busy_seen", seen_busy, 0);
        end

        // Single byte 0x55 and pop-to-start latency.
        @(negedge clk);
        base = rd_cnt0;
        q0.push_back(8'h55); exp_q.push_back(10'h2AA);
        wait_sig(0, 20, "t1_rd_seen", n);
        wait_sig(1, 10, "t1_start_seen", n);
        check("t1_rd_to_start", n, 2);
        wait_sig(2, 200, "t1_done_seen", n);
        repeat (5) @(negedge clk);
        check("t1_pop_count", rd_cnt0 - base, 1);

        // Back-to-back 0xA3, 0x0F with a two-cycle gap.
        @(negedge clk);
        base = rd_cnt0;
        q0.push_back(8'hA3); exp_q.push_back(10'h346);
        q0.push_back(8'h0F); exp_q.push_back(10'h21E);
        wait_sig(2, 300, "t2_done1_seen", n);
        wait_sig(1, 10, "t2_start2_seen", n);
        check("t2_gap", n - 1, 2);
        wait_sig(2, 200, "t2_done2_seen", n);
        repeat (5) @(negedge clk);
        check("t2_pop_count", rd_cnt0 - base, 2);

        // Even parity on 0x07: line 0,1,1,1,0,0,0,0,0,1(par),1 over 110 cycles.
        @(negedge clk);
        q1.push_back(8'h07);
        wait_sig(3, 20, "t3_start_seen", n);
        pline = '0; pdone = -1;
        for (int c = 0; c < 110; c++) begin
            if (c > 0) @(negedge clk);
            if (c % 10 == 5) pline[c/10] = txd1;
            if (done1 === 1'b1 && pdone < 0) pdone = c;
        end
        check("t3_line", pline, 11'h60E);
        check("t3_done_pos", pdone, 109);
        @(negedge clk);
        check("t3_idle_after", busy1, 0);

        // tx_en dropped in DATA bit 3 of 0xFF: frame completes, no further pop.
        @(negedge clk);
        base = rd_cnt0;
        q0.push_back(8'hFF); exp_q.push_back(10'h3FE);
        q0.push_back(8'h11);
        q0.push_back(8'h22);
        wait_sig(1, 20, "t5_start_seen", n);
        repeat (42) @(negedge clk);
        tx_en = 1'b0;
        wait_sig(2, 100, "t5_done_seen", n);
        repeat (30) @(negedge clk);
        check("t5_pop_count", rd_cnt0 - base, 1);
        check("t5_busy", busy0, 0);
        check("t5_fifo_left", q0.size(), 2);

        // Reset mid DATA of 0x11: async idle, 0x11 lost, 0x22 follows normally.
        base = rd_cnt0;
        exp_q.push_back(10'h222);
        exp_q.push_back(10'h244);
        @(negedge clk);
        tx_en = 1'b1;
        wait_sig(1, 20, "t6_start_seen", n);
        repeat (35) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_async_txd", txd0, 1);
        check("t6_async_busy", busy0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        wait_sig(2, 300, "t6_done_seen", n);
        repeat (5) @(negedge clk);
        check("t6_pop_count", rd_cnt0 - base, 2);
        check("t6_fifo_left", q0.size(), 0);

        check("pop_on_empty", pop_empty0 + pop_empty1, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
